// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter slice.
// Optional statistics outputs are enabled by defining DATA_ARB_STATS_EN.
package data_ram_arbiter_pkg;

   localparam int AW               = 16;
   localparam int DW               = 32;
   localparam int STARVE_LIMIT_DEF = 8;

   localparam int ARB_CORE = 0;
   localparam int ARB_HOST = 1;

   typedef enum logic [1:0] {
      TAG_NONE = 2'd0,
      TAG_CORE = 2'd1,
      TAG_HOST = 2'd2
   } rd_tag_e;

   function automatic logic is_read(input logic [3:0] we);
      return (we == 4'h0);
   endfunction

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester and RAM-side signal bundle for the data RAM arbiter.
// slave = arbiter view, master = requesters plus RAM view.
interface data_ram_arbiter_if;
   import data_ram_arbiter_pkg::*;

   logic          c_req;
   logic [3:0]    c_we;
   logic [AW-1:0] c_addr;
   logic [DW-1:0] c_wdata;
   logic          c_gnt;
   logic          c_rvalid;
   logic [DW-1:0] c_rdata;

   logic          h_req;
   logic [3:0]    h_we;
   logic [AW-1:0] h_addr;
   logic [DW-1:0] h_wdata;
   logic          h_gnt;
   logic          h_rvalid;
   logic [DW-1:0] h_rdata;

   logic          ram_en;
   logic [3:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, ram_dout,
      output c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata,
      output ram_en, ram_we, ram_addr, ram_din
   );

   modport master (
      output c_req, c_we, c_addr, c_wdata, h_req, h_we, h_addr, h_wdata, ram_dout,
      input  c_gnt, c_rvalid, c_rdata, h_gnt, h_rvalid, h_rdata,
      input  ram_en, ram_we, ram_addr, ram_din
   );

endinterface

// File: rtl/data_ram_arbiter_starve_ctr.sv
// HOST starvation counter: counts consecutive denied cycles of a pending
// HOST request, saturating at the limit, and flags urgency at the limit.
module arb_starve_ctr #(
   parameter int STARVE_LIMIT = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       h_req,
   input  logic       h_gnt,
   output logic [7:0] starve_cnt,
   output logic       host_urgent
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= 8'd0;
      end else if (!h_req || h_gnt) begin
         starve_cnt <= 8'd0;
      end else if (starve_cnt != LIMIT) begin
         starve_cnt <= starve_cnt + 8'd1;
      end
   end

   assign host_urgent = (starve_cnt == LIMIT);

endmodule

// File: rtl/data_ram_arbiter.sv
// Single-port data RAM arbiter: CORE has fixed priority, HOST wins once starved.
// Define DATA_ARB_STATS_EN to add grant counters and the HOST stall maximum.
module data_ram_arbiter
   import data_ram_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   data_ram_arbiter_if.slave   bus
`ifdef DATA_ARB_STATS_EN
   ,
   output logic [15:0]         c_gnt_cnt,
   output logic [15:0]         h_gnt_cnt,
   output logic [7:0]          h_stall_max
`endif
);

   logic [1:0]    gnt;
   logic [7:0]    starve_cnt;
   logic          host_urgent;
   rd_tag_e       rd_tag_q;
   rd_tag_e       rd_tag_d;
   logic [DW-1:0] c_rdata_q;
   logic [DW-1:0] h_rdata_q;

   arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
      .clk         (clk),
      .rst         (rst),
      .h_req       (bus.h_req),
      .h_gnt       (gnt[ARB_HOST]),
      .starve_cnt  (starve_cnt),
      .host_urgent (host_urgent)
   );

   always_comb begin
      gnt          = 2'b00;
      bus.ram_we   = 4'h0;
      bus.ram_addr = '0;
      bus.ram_din  = '0;
      rd_tag_d     = TAG_NONE;
      if (host_urgent && bus.h_req)
         gnt[ARB_HOST] = 1'b1;
      else if (bus.c_req)
         gnt[ARB_CORE] = 1'b1;
      else if (bus.h_req)
         gnt[ARB_HOST] = 1'b1;

      if (gnt[ARB_CORE]) begin
         bus.ram_we   = bus.c_we;
         bus.ram_addr = bus.c_addr;
         bus.ram_din  = bus.c_wdata;
         if (is_read(bus.c_we)) rd_tag_d = TAG_CORE;
      end else if (gnt[ARB_HOST]) begin
         bus.ram_we   = bus.h_we;
         bus.ram_addr = bus.h_addr;
         bus.ram_din  = bus.h_wdata;
         if (is_read(bus.h_we)) rd_tag_d = TAG_HOST;
      end
   end

   assign bus.c_gnt  = gnt[ARB_CORE];
   assign bus.h_gnt  = gnt[ARB_HOST];
   assign bus.ram_en = |gnt;

   // Read data is passed straight through in the valid cycle, then held.
   assign bus.c_rvalid = (rd_tag_q == TAG_CORE);
   assign bus.h_rvalid = (rd_tag_q == TAG_HOST);
   assign bus.c_rdata  = bus.c_rvalid ? bus.ram_dout : c_rdata_q;
   assign bus.h_rdata  = bus.h_rvalid ? bus.ram_dout : h_rdata_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_tag_q  <= TAG_NONE;
         c_rdata_q <= '0;
         h_rdata_q <= '0;
      end else begin
         rd_tag_q  <= rd_tag_d;
         c_rdata_q <= bus.c_rdata;
         h_rdata_q <= bus.h_rdata;
      end
   end

`ifdef DATA_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_gnt_cnt   <= 16'd0;
         h_gnt_cnt   <= 16'd0;
         h_stall_max <= 8'd0;
      end else begin
         if (gnt[ARB_CORE] && c_gnt_cnt != 16'hFFFF) c_gnt_cnt <= c_gnt_cnt + 16'd1;
         if (gnt[ARB_HOST] && h_gnt_cnt != 16'hFFFF) h_gnt_cnt <= h_gnt_cnt + 16'd1;
         if (starve_cnt > h_stall_max) h_stall_max <= starve_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a behavioural RAM.
// Stats outputs are checked when DATA_ARB_STATS_EN is defined.
module tb_data_ram_arbiter;
   import data_ram_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   data_ram_arbiter_if bus ();

`ifdef DATA_ARB_STATS_EN
   logic [15:0] c_gnt_cnt, h_gnt_cnt;
   logic [7:0]  h_stall_max;
`endif

   data_ram_arbiter #(.STARVE_LIMIT(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
`ifdef DATA_ARB_STATS_EN
      ,
      .c_gnt_cnt   (c_gnt_cnt),
      .h_gnt_cnt   (h_gnt_cnt),
      .h_stall_max (h_stall_max)
`endif
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:255];
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      bus.ram_dout = 32'h0;
   end

   always @(posedge clk) begin
      if (bus.ram_en) begin
         if (bus.ram_we == 4'h0) begin
            bus.ram_dout <= mem[bus.ram_addr[7:0]];
         end else begin
            for (int b = 0; b < 4; b++)
               if (bus.ram_we[b]) mem[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_din[8*b +: 8];
         end
      end
   end

   // A requester must keep req high until it is granted.
   logic c_wait = 1'b0, h_wait = 1'b0;
   always @(posedge clk) begin
      if (rst) begin
         c_wait = 1'b0;
         h_wait = 1'b0;
      end else begin
         if (c_wait && !bus.c_req) $error("CORE dropped req before gnt");
         if (h_wait && !bus.h_req) $error("HOST dropped req before gnt");
         c_wait = bus.c_req && !bus.c_gnt;
         h_wait = bus.h_req && !bus.h_gnt;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_c(input logic req, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
      bus.c_req = req; bus.c_we = we; bus.c_addr = a; bus.c_wdata = d;
   endtask

   task automatic drive_h(input logic req, input logic [3:0] we, input logic [15:0] a, input logic [31:0] d);
      bus.h_req = req; bus.h_we = we; bus.h_addr = a; bus.h_wdata = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive_c(1'b1, 4'h0, 16'h0000, 32'h0);
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      step(); step();
      n_cmp++; if (bus.c_gnt !== 1'b1) begin n_err++; $display("FAIL rst_c_gnt: got %h want 1", bus.c_gnt); end
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_c_rvalid: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.h_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_h_rvalid: got %h want 0", bus.h_rvalid); end
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      step();
      rst = 1'b0;
      step();
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL post_rst_c_rvalid: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'h0) begin n_err++; $display("FAIL post_rst_c_rdata: got %h want 0", bus.c_rdata); end
      n_cmp++; if (bus.h_rdata !== 32'h0) begin n_err++; $display("FAIL post_rst_h_rdata: got %h want 0", bus.h_rdata); end
      n_cmp++; if (bus.ram_en !== 1'b0) begin n_err++; $display("FAIL idle_ram_en: got %h want 0", bus.ram_en); end
      n_cmp++; if (bus.ram_we !== 4'h0) begin n_err++; $display("FAIL idle_ram_we: got %h want 0", bus.ram_we); end
`ifdef DATA_ARB_STATS_EN
      n_cmp++; if (c_gnt_cnt !== 16'd0) begin n_err++; $display("FAIL rst_c_gnt_cnt: got %0d want 0", c_gnt_cnt); end
      n_cmp++; if (h_stall_max !== 8'd0) begin n_err++; $display("FAIL rst_h_stall_max: got %0d want 0", h_stall_max); end
`endif
   endtask

   task automatic test_core_write_read();
      drive_c(1'b1, 4'hF, 16'h0010, 32'hDEADBEEF);
      #1;
      n_cmp++; if (bus.c_gnt !== 1'b1) begin n_err++; $display("FAIL wr_c_gnt: got %h want 1", bus.c_gnt); end
      n_cmp++; if (bus.ram_we !== 4'hF) begin n_err++; $display("FAIL wr_ram_we: got %h want f", bus.ram_we); end
      n_cmp++; if (bus.ram_din !== 32'hDEADBEEF) begin n_err++; $display("FAIL wr_ram_din: got %h want deadbeef", bus.ram_din); end
      step();
      drive_c(1'b1, 4'h0, 16'h0010, 32'h0);
      #1;
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL wr_no_rvalid: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.c_gnt !== 1'b1) begin n_err++; $display("FAIL rd_c_gnt: got %h want 1", bus.c_gnt); end
      n_cmp++; if (bus.ram_addr !== 16'h0010) begin n_err++; $display("FAIL rd_ram_addr: got %h want 0010", bus.ram_addr); end
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      n_cmp++; if (bus.c_rvalid !== 1'b1) begin n_err++; $display("FAIL rd_c_rvalid: got %h want 1", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_c_rdata: got %h want deadbeef", bus.c_rdata); end
      n_cmp++; if (bus.h_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_h_rvalid: got %h want 0", bus.h_rvalid); end
      step();
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL rd_rvalid_drop: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_rdata_hold: got %h want deadbeef", bus.c_rdata); end
   endtask

   task automatic test_byte_write();
      drive_c(1'b1, 4'b0010, 16'h0010, 32'h0000AB00);
      step();
      drive_c(1'b1, 4'h0, 16'h0010, 32'h0);
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      n_cmp++; if (bus.c_rvalid !== 1'b1) begin n_err++; $display("FAIL byte_rvalid: got %h want 1", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'hDEADABEF) begin n_err++; $display("FAIL byte_rdata: got %h want deadabef", bus.c_rdata); end
      step();
   endtask

   task automatic test_starve();
      logic exp_h;
      drive_c(1'b1, 4'hF, 16'h0020, 32'h00000001);
      drive_h(1'b1, 4'hF, 16'h0030, 32'h00000002);
      for (int k = 0; k <= 8; k++) begin
         #1;
         exp_h = (k == 8);
         n_cmp++; if (bus.h_gnt !== exp_h) begin n_err++; $display("FAIL starve_h_gnt[%0d]: got %h want %h", k, bus.h_gnt, exp_h); end
         n_cmp++; if (bus.c_gnt !== !exp_h) begin n_err++; $display("FAIL starve_c_gnt[%0d]: got %h want %h", k, bus.c_gnt, !exp_h); end
         if (k == 8) begin
            n_cmp++; if (bus.ram_addr !== 16'h0030) begin n_err++; $display("FAIL starve_ram_addr: got %h want 0030", bus.ram_addr); end
         end
         step();
      end
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      #1;
      n_cmp++; if (bus.c_gnt !== 1'b1) begin n_err++; $display("FAIL starve_c_after: got %h want 1", bus.c_gnt); end
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      step();
   endtask

   task automatic test_alternating_reads();
      drive_h(1'b1, 4'hF, 16'h0001, 32'hA5A50001);
      step();
      drive_h(1'b1, 4'hF, 16'h0002, 32'h5A5A0002);
      step();
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      drive_c(1'b1, 4'h0, 16'h0001, 32'h0);
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      drive_h(1'b1, 4'h0, 16'h0002, 32'h0);
      #1;
      n_cmp++; if (bus.c_rvalid !== 1'b1) begin n_err++; $display("FAIL alt_c_rvalid: got %h want 1", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'hA5A50001) begin n_err++; $display("FAIL alt_c_rdata: got %h want a5a50001", bus.c_rdata); end
      n_cmp++; if (bus.h_rvalid !== 1'b0) begin n_err++; $display("FAIL alt_h_quiet: got %h want 0", bus.h_rvalid); end
      step();
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      drive_c(1'b1, 4'h0, 16'h0001, 32'h0);
      #1;
      n_cmp++; if (bus.h_rvalid !== 1'b1) begin n_err++; $display("FAIL alt_h_rvalid: got %h want 1", bus.h_rvalid); end
      n_cmp++; if (bus.h_rdata !== 32'h5A5A0002) begin n_err++; $display("FAIL alt_h_rdata: got %h want 5a5a0002", bus.h_rdata); end
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL alt_c_quiet: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'hA5A50001) begin n_err++; $display("FAIL alt_c_hold: got %h want a5a50001", bus.c_rdata); end
      step();
      // both read the same word: CORE first, HOST next cycle
      drive_c(1'b1, 4'h0, 16'h0002, 32'h0);
      drive_h(1'b1, 4'h0, 16'h0002, 32'h0);
      #1;
      n_cmp++; if (bus.h_gnt !== 1'b0) begin n_err++; $display("FAIL same_h_wait: got %h want 0", bus.h_gnt); end
      n_cmp++; if (bus.c_rdata !== 32'hA5A50001) begin n_err++; $display("FAIL alt_c_rd2: got %h want a5a50001", bus.c_rdata); end
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      #1;
      n_cmp++; if (bus.h_gnt !== 1'b1) begin n_err++; $display("FAIL same_h_gnt: got %h want 1", bus.h_gnt); end
      n_cmp++; if (bus.c_rdata !== 32'h5A5A0002) begin n_err++; $display("FAIL same_c_rdata: got %h want 5a5a0002", bus.c_rdata); end
      step();
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      n_cmp++; if (bus.h_rvalid !== 1'b1 || bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL same_h_rvalid: got h=%h c=%h want h=1 c=0", bus.h_rvalid, bus.c_rvalid); end
      n_cmp++; if (bus.h_rdata !== 32'h5A5A0002) begin n_err++; $display("FAIL same_h_rdata: got %h want 5a5a0002", bus.h_rdata); end
      step();
   endtask

   task automatic test_reset_mid_read();
      drive_c(1'b1, 4'h0, 16'h0010, 32'h0);
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      rst = 1'b1;
      #1;
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_rvalid_in_rst: got %h want 0", bus.c_rvalid); end
      step();
      rst = 1'b0;
      step();
      n_cmp++; if (bus.c_rvalid !== 1'b0) begin n_err++; $display("FAIL midrst_rvalid_after: got %h want 0", bus.c_rvalid); end
      n_cmp++; if (bus.c_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_rdata: got %h want 0", bus.c_rdata); end
`ifdef DATA_ARB_STATS_EN
      drive_c(1'b1, 4'hF, 16'h0040, 32'h1);
      drive_h(1'b1, 4'hF, 16'h0041, 32'h2);
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      step();
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      drive_c(1'b1, 4'hF, 16'h0042, 32'h3);
      step();
      drive_c(1'b0, 4'h0, 16'h0000, 32'h0);
      drive_h(1'b1, 4'hF, 16'h0043, 32'h4);
      step();
      drive_h(1'b0, 4'h0, 16'h0000, 32'h0);
      n_cmp++; if (c_gnt_cnt !== 16'd2) begin n_err++; $display("FAIL stats_c_gnt_cnt: got %0d want 2", c_gnt_cnt); end
      n_cmp++; if (h_gnt_cnt !== 16'd2) begin n_err++; $display("FAIL stats_h_gnt_cnt: got %0d want 2", h_gnt_cnt); end
      n_cmp++; if (h_stall_max !== 8'd1) begin n_err++; $display("FAIL stats_h_stall_max: got %0d want 1", h_stall_max); end
`endif
      step();
   endtask

   initial begin
      test_reset();
      test_core_write_read();
      test_byte_write();
      test_starve();
      test_alternating_reads();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, got no end want end");
      $fatal(1, "timeout");
   end

endmodule
